// File: rtl/counter_checker_pkg.sv
// Shared definitions for the counter checker: FSM state type and the counter
// next-value rule that both the checker and any counter variant agree on.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } ctr_chk_state_t;

    localparam int STEP_MAX_W = 32;

    // Counter rule on a base value; the result is masked to 'width' bits so the
    // increment/decrement wrap modulo 2^width.
    function automatic logic [STEP_MAX_W-1:0] step(
        input logic [STEP_MAX_W-1:0] base,
        input logic                  up,
        input logic                  down,
        input logic                  load,
        input logic [STEP_MAX_W-1:0] init,
        input int unsigned           width
    );
        logic [STEP_MAX_W-1:0] mask;
        logic [STEP_MAX_W-1:0] r;
        mask = (width >= STEP_MAX_W) ? '1 : ((32'd1 << width) - 32'd1);
        r    = base;
        if (load)
            r = init;
        else if (up && !down)
            r = base + 32'd1;
        else if (down && !up)
            r = base - 32'd1;
        return r & mask;
    endfunction

endpackage

// File: rtl/counter_checker_if.sv
// Observation bus between an up/down counter and its checker: the mirrored
// counter controls and count in, the checker's verdicts out.
interface counter_checker_if #(
    parameter int width = 4,
    parameter int ERR_W = 8
);
    logic             enable;
    logic             clear_err;
    logic             mon_up;
    logic             mon_down;
    logic             mon_load;
    logic [width-1:0] mon_init_value;
    logic [width-1:0] mon_count;
    logic [width-1:0] expected;
    logic             synced;
    logic             mismatch;
    logic             error_sticky;
    logic [ERR_W-1:0] error_count;
    logic [width-1:0] first_bad_count;
    logic [width-1:0] first_bad_expected;

    modport master (
        output enable, clear_err, mon_up, mon_down, mon_load, mon_init_value, mon_count,
        input  expected, synced, mismatch, error_sticky, error_count,
               first_bad_count, first_bad_expected
    );

    modport slave (
        input  enable, clear_err, mon_up, mon_down, mon_load, mon_init_value, mon_count,
        output expected, synced, mismatch, error_sticky, error_count,
               first_bad_count, first_bad_expected
    );
endinterface

// File: rtl/counter_checker_err_log.sv
// Error bookkeeping for the counter checker: saturating mismatch count, sticky
// flag, and a snapshot of the first offending count/reference pair.
module ctr_err_log #(
    parameter int width = 4,
    parameter int ERR_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_hit,
    input  logic [width-1:0] i_count,
    input  logic [width-1:0] i_expected,
    output logic             o_sticky,
    output logic [ERR_W-1:0] o_count,
    output logic [width-1:0] o_first_count,
    output logic [width-1:0] o_first_expected
);
    logic             r_sticky;
    logic [ERR_W-1:0] r_count;
    logic [width-1:0] r_first_count;
    logic [width-1:0] r_first_expected;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sticky         <= 1'b0;
            r_count          <= '0;
            r_first_count    <= '0;
            r_first_expected <= '0;
        end else if (i_clear) begin
            r_sticky         <= 1'b0;
            r_count          <= '0;
            r_first_count    <= '0;
            r_first_expected <= '0;
        end else if (i_hit) begin
            if (r_count != '1)
                r_count <= r_count + 1'b1;
            // Only the first mismatch since the last clear is captured.
            if (!r_sticky) begin
                r_sticky         <= 1'b1;
                r_first_count    <= i_count;
                r_first_expected <= i_expected;
            end
        end
    end

    assign o_sticky         = r_sticky;
    assign o_count          = r_count;
    assign o_first_count    = r_first_count;
    assign o_first_expected = r_first_expected;
endmodule

// File: rtl/counter_checker.sv
// Synthesizable monitor for an up/down counter: keeps its own reference count,
// resyncs to the observed count every cycle and flags any divergence.
module counter_checker
    import counter_pkg::*;
#(
    parameter int width         = 4,
    parameter int ERR_W         = 8,
    parameter bit STOP_ON_ERROR = 1'b0
) (
    input logic             clock,
    input logic             reset,
    counter_checker_if.slave bus
);
    ctr_chk_state_t   r_state;
    ctr_chk_state_t   w_state_nxt;
    logic [width-1:0] r_expected;
    logic [width-1:0] w_expected_nxt;
    logic [width-1:0] w_stepped;
    logic             r_mismatch;
    logic             w_hit;

    // Resync from the observed count so one counter fault yields one pulse.
    assign w_stepped = width'(step(32'(bus.mon_count), bus.mon_up, bus.mon_down,
                                   bus.mon_load, 32'(bus.mon_init_value), width));

    assign w_hit = bus.enable && !bus.clear_err && (r_state == TRACK) &&
                   (bus.mon_count != r_expected);

    always_comb begin
        w_state_nxt    = r_state;
        w_expected_nxt = r_expected;
        if (bus.clear_err) begin
            w_state_nxt = IDLE;
            if (bus.enable && bus.mon_load) begin
                w_state_nxt    = TRACK;
                w_expected_nxt = bus.mon_init_value;
            end
        end else if (bus.enable) begin
            unique case (r_state)
                IDLE: begin
                    if (bus.mon_load) begin
                        w_state_nxt    = TRACK;
                        w_expected_nxt = bus.mon_init_value;
                    end
                end
                TRACK: begin
                    w_expected_nxt = w_stepped;
                    if (w_hit && STOP_ON_ERROR)
                        w_state_nxt = FAULT;
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_expected <= '0;
            r_mismatch <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_expected <= w_expected_nxt;
            r_mismatch <= w_hit;
        end
    end

    ctr_err_log #(
        .width (width),
        .ERR_W (ERR_W)
    ) u_err_log (
        .clock            (clock),
        .reset            (reset),
        .i_clear          (bus.clear_err),
        .i_hit            (w_hit),
        .i_count          (bus.mon_count),
        .i_expected       (r_expected),
        .o_sticky         (bus.error_sticky),
        .o_count          (bus.error_count),
        .o_first_count    (bus.first_bad_count),
        .o_first_expected (bus.first_bad_expected)
    );

    assign bus.expected = r_expected;
    assign bus.synced   = (r_state != IDLE);
    assign bus.mismatch = r_mismatch;
endmodule
